gray_counter_param: RTL and testbench
=====================================

// Module: gray_counter_param
//
// PURPOSE
// - Parametrised Gray-code counter; the next generation of the fixed 4-bit Gray counter FSM.
// - Counts modulo MODULUS, up or down.
// - Supports enable, synchronous Gray-coded load, and a wrap or saturate mode.
// - Gives Gray and binary views of the count, plus terminal-count, wrap and load-error flags.
// - Used as a generic sequencer / pointer source wherever a single-bit-change count is needed.
//
// PARAMETERS
// WIDTH    4           count width in bits; legal range 2..16
// MODULUS  2**WIDTH    count length; legal range 2..2**WIDTH; elaboration-time $error outside range
//
// PORTS
// clk        in   1      single clock; all state updates on posedge clk
// reset      in   1      synchronous reset, active-high
// en         in   1      count enable; one step per cycle while high
// up         in   1      direction: 1 = increment, 0 = decrement
// sat_mode   in   1      1 = saturate at end of range, 0 = wrap modulo MODULUS
// load       in   1      synchronous load strobe
// load_gray  in   WIDTH  Gray-coded load value
// gray_out   out  WIDTH  registered Gray count: bin ^ (bin >> 1)
// bin_out    out  WIDTH  registered binary count, range 0..MODULUS-1
// tc         out  1      registered; count is at end of range in the current direction
// wrap       out  1      registered 1-cycle pulse; last update crossed the modulus boundary
// load_err   out  1      registered 1-cycle pulse; decoded load value was >= MODULUS
//
// BEHAVIOUR
// - Reset (synchronous, highest priority):
//   - bin_out = 0, gray_out = 0, wrap = 0, load_err = 0.
//   - tc = ~up, sampled in the reset cycle.
// - Update priority per posedge: reset > load > en > hold.
// - Latency: one cycle from the sampled controls to the outputs. gray_out and bin_out always
//   change in the same edge.
// - Load:
//   - v = gray2bin(load_gray).
//   - If v < MODULUS: bin <= v.
//   - Else: bin <= 0 and load_err pulses for one cycle.
//   - en is ignored in a load cycle; wrap = 0 in a load cycle.
// - Count, en=1, up=1:
//   - bin <  MODULUS-1: bin <= bin+1.
//   - bin == MODULUS-1, sat_mode=0: bin <= 0 and wrap pulses.
//   - bin == MODULUS-1, sat_mode=1: hold; no wrap.
// - Count, en=1, up=0:
//   - bin >  0: bin <= bin-1.
//   - bin == 0, sat_mode=0: bin <= MODULUS-1 and wrap pulses.
//   - bin == 0, sat_mode=1: hold; no wrap.
// - en=0 and no load: hold; wrap and load_err are 0.
// - tc = up ? (next_bin == MODULUS-1) : (next_bin == 0), using the up value sampled this edge.
// - Arithmetic is done on the binary state, WIDTH bits, with explicit modulus compare. Never rely
//   on natural overflow unless MODULUS == 2**WIDTH.
// - Single-bit Gray change is guaranteed on every step, including wrap, only when
//   MODULUS == 2**WIDTH. Otherwise the wrap step may change several bits; this is intended.
// - Direction or mode change mid-count takes effect on the same edge; no restart.
// - Reset asserted mid-count or during a load overrides everything that cycle.
//
// STRUCTURE
// - Shared package gray_pkg:
//   - functions bin2gray and gray2bin, parametrised by width via a
//     parameterised class static function or explicit loop.
//   - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
// - Sub-module gray_decode: combinational gray2bin for load_gray, reused by the future Gray-pointer
//   FIFO.
// - Core: one always_ff for bin/flags, one always_comb for next_bin/wrap_nxt; gray_out registered
//   from bin2gray(next_bin).
//
// TESTING
// - Reset, then WIDTH=4, MODULUS=16, up=1, en=1, 17 cycles:
//   - gray_out = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
//   - wrap pulses once on the return to 0; tc high with 8.
// - MODULUS=24, WIDTH=5, down from reset:
//   - bin_out 0 -> 23 (gray 0x1C) with wrap=1.
//   - Then 22 (gray 0x1D); tc high only at bin 0.
// - sat_mode=1, up=1 at bin 15:
//   - Holds 15 / gray 8 for 3 cycles; wrap stays 0; tc stays 1.
//   - Flip up=0: next value is 14.
// - load=1, load_gray=0x6 with en=1 -> bin_out=4, gray_out=6, wrap=0 next cycle.
// - MODULUS=10, load_gray=0xF (bin 10) -> bin_out=0, load_err=1 for exactly one cycle.
// - Reset asserted in the same cycle as load and en -> all outputs at reset values next cycle.
//   Random en/up/load for 10k cycles checked against a scoreboard model.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and count-mode type. Conversions run at full
// MAX_WIDTH; callers zero-extend narrower values and truncate the result.
package gray_pkg;

   localparam int unsigned MAX_WIDTH = 16;

   typedef logic [MAX_WIDTH-1:0] word_t;

   typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

   function automatic word_t bin2gray(input word_t b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of its Gray bit and every Gray bit above it
   function automatic word_t gray2bin(input word_t g);
      word_t b;
      b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
      for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_counter_param_if.sv
// Control and status bundle of the parametrised Gray counter.
interface gray_counter_param_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up;
   logic             sat_mode;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] gray_out;
   logic [WIDTH-1:0] bin_out;
   logic             tc;
   logic             wrap;
   logic             load_err;

   modport master (
      output en, up, sat_mode, load, load_gray,
      input  gray_out, bin_out, tc, wrap, load_err
   );

   modport slave (
      input  en, up, sat_mode, load, load_gray,
      output gray_out, bin_out, tc, wrap, load_err
   );
endinterface

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decoder, shared with the Gray-pointer FIFO.
module gray_decode
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin_c
);

   always_comb begin
      bin_c = WIDTH'(gray2bin(MAX_WIDTH'(gray)));
   end

endmodule

// File: rtl/gray_counter_param.sv
// Modulo-MODULUS up/down Gray counter with load, wrap/saturate mode and
// binary view; all outputs registered, one cycle after the sampled controls.
module gray_counter_param
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 2**WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   gray_counter_param_if.slave  bus
);

   localparam int unsigned    MOD_MAX = 32'd1 << WIDTH;
   localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 32'd1);

   if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("gray_counter_param: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
   end
   if (MODULUS < 2 || MODULUS > MOD_MAX) begin : g_bad_modulus
      $error("gray_counter_param: MODULUS %0d outside 2..%0d", MODULUS, MOD_MAX);
   end

   logic [WIDTH-1:0] load_bin_c;
   logic [WIDTH-1:0] next_bin;
   logic             wrap_nxt;
   logic             err_nxt;
   logic             tc_nxt;
   cnt_mode_e        mode;

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic             tc_q;
   logic             wrap_q;
   logic             err_q;

   gray_decode #(.WIDTH(WIDTH)) u_decode (
      .gray  (bus.load_gray),
      .bin_c (load_bin_c)
   );

   assign mode = cnt_mode_e'(bus.sat_mode);

   // Next binary count: load > enable > hold; boundaries compared explicitly
   always_comb begin
      next_bin = bin_q;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (bus.load) begin
         if (32'(load_bin_c) < MODULUS) begin
            next_bin = load_bin_c;
         end else begin
            next_bin = '0;
            err_nxt  = 1'b1;
         end
      end else if (bus.en) begin
         if (bus.up) begin
            if (bin_q != LAST) begin
               next_bin = bin_q + WIDTH'(1);
            end else if (mode == CNT_WRAP) begin
               next_bin = '0;
               wrap_nxt = 1'b1;
            end
         end else begin
            if (bin_q != '0) begin
               next_bin = bin_q - WIDTH'(1);
            end else if (mode == CNT_WRAP) begin
               next_bin = LAST;
               wrap_nxt = 1'b1;
            end
         end
      end
      tc_nxt = bus.up ? (next_bin == LAST) : (next_bin == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         gray_q <= '0;
         tc_q   <= ~bus.up;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         bin_q  <= next_bin;
         gray_q <= WIDTH'(bin2gray(MAX_WIDTH'(next_bin)));
         tc_q   <= tc_nxt;
         wrap_q <= wrap_nxt;
         err_q  <= err_nxt;
      end
   end

   assign bus.bin_out  = bin_q;
   assign bus.gray_out = gray_q;
   assign bus.tc       = tc_q;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = err_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three configurations (16/4, 24/5, 10/4)
// checked every cycle against an arithmetic model plus directed scenarios.
module tb_gray_counter_param;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   logic        en_v [3];
   logic        up_v [3];
   logic        sat_v[3];
   logic        ld_v [3];
   logic [15:0] lg_v [3];

   int bin_o[3], gray_o[3], tc_o[3], wrap_o[3], err_o[3];

   int mods[3];
   int wids[3];

   int mcnt[3], mtc[3], mwrap[3], merr[3];

   int n_chk  = 0;
   int n_fail = 0;

   gray_counter_param_if #(.WIDTH(4)) if0 ();
   gray_counter_param_if #(.WIDTH(5)) if1 ();
   gray_counter_param_if #(.WIDTH(4)) if2 ();

   gray_counter_param #(.WIDTH(4), .MODULUS(16)) dut0 (.clk(clk), .reset(reset), .bus(if0));
   gray_counter_param #(.WIDTH(5), .MODULUS(24)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   gray_counter_param #(.WIDTH(4), .MODULUS(10)) dut2 (.clk(clk), .reset(reset), .bus(if2));

   assign if0.en = en_v[0];  assign if0.up = up_v[0];  assign if0.sat_mode = sat_v[0];
   assign if0.load = ld_v[0]; assign if0.load_gray = lg_v[0][3:0];
   assign if1.en = en_v[1];  assign if1.up = up_v[1];  assign if1.sat_mode = sat_v[1];
   assign if1.load = ld_v[1]; assign if1.load_gray = lg_v[1][4:0];
   assign if2.en = en_v[2];  assign if2.up = up_v[2];  assign if2.sat_mode = sat_v[2];
   assign if2.load = ld_v[2]; assign if2.load_gray = lg_v[2][3:0];

   assign bin_o[0] = 32'(if0.bin_out); assign gray_o[0] = 32'(if0.gray_out);
   assign tc_o[0] = 32'(if0.tc); assign wrap_o[0] = 32'(if0.wrap); assign err_o[0] = 32'(if0.load_err);
   assign bin_o[1] = 32'(if1.bin_out); assign gray_o[1] = 32'(if1.gray_out);
   assign tc_o[1] = 32'(if1.tc); assign wrap_o[1] = 32'(if1.wrap); assign err_o[1] = 32'(if1.load_err);
   assign bin_o[2] = 32'(if2.bin_out); assign gray_o[2] = 32'(if2.gray_out);
   assign tc_o[2] = 32'(if2.tc); assign wrap_o[2] = 32'(if2.wrap); assign err_o[2] = 32'(if2.load_err);

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Gray decode as a running XOR of all right shifts
   function automatic int g2b(input int g);
      int v = 0;
      for (int s = g; s != 0; s = s >> 1) v = v ^ s;
      return v;
   endfunction

   // Reference: what each counter holds after the edge just taken
   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         int m = mods[d];
         mwrap[d] = 0;
         merr[d]  = 0;
         if (reset) begin
            mcnt[d] = 0;
         end else if (ld_v[d]) begin
            int v = g2b(int'(lg_v[d]));
            if (v < m) mcnt[d] = v;
            else begin
               mcnt[d] = 0;
               merr[d] = 1;
            end
         end else if (en_v[d]) begin
            if (up_v[d]) begin
               if (mcnt[d] < m - 1) mcnt[d] = mcnt[d] + 1;
               else if (!sat_v[d]) begin
                  mcnt[d]  = 0;
                  mwrap[d] = 1;
               end
            end else begin
               if (mcnt[d] > 0) mcnt[d] = mcnt[d] - 1;
               else if (!sat_v[d]) begin
                  mcnt[d]  = m - 1;
                  mwrap[d] = 1;
               end
            end
         end
         mtc[d] = up_v[d] ? int'(mcnt[d] == m - 1) : int'(mcnt[d] == 0);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_bin", d),  bin_o[d],  mcnt[d]);
         chk($sformatf("d%0d_gray", d), gray_o[d], mcnt[d] ^ (mcnt[d] >> 1));
         chk($sformatf("d%0d_tc", d),   tc_o[d],   mtc[d]);
         chk($sformatf("d%0d_wrap", d), wrap_o[d], mwrap[d]);
         chk($sformatf("d%0d_err", d),  err_o[d],  merr[d]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         en_v[d]  = 1'b0;
         ld_v[d]  = 1'b0;
         sat_v[d] = 1'b0;
         lg_v[d]  = '0;
      end
   endtask

   initial begin
      int seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
      mods = '{16, 24, 10};
      wids = '{4, 5, 4};
      idle_all();
      up_v = '{1'b1, 1'b0, 1'b1};

      // Reset: tc follows ~up
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_bin0", bin_o[0], 0);
      chk("rst_gray0", gray_o[0], 0);
      chk("rst_tc_up", tc_o[0], 0);
      chk("rst_tc_down", tc_o[1], 1);

      // Full 16-state up sequence
      en_v[0] = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         chk($sformatf("seq_gray[%0d]", i), gray_o[0], seq[i+1 > 16 ? 16 : i+1]);
         chk($sformatf("seq_wrap[%0d]", i), wrap_o[0], int'(i == 15));
         chk($sformatf("seq_tc[%0d]", i),   tc_o[0],   int'(i == 14));
         if (i == 15) en_v[0] = 1'b0;
      end
      idle_all();

      // Modulus 24 counting down from 0
      en_v[1] = 1'b1;
      tick();
      chk("m24_bin23", bin_o[1], 23);
      chk("m24_gray1c", gray_o[1], 'h1C);
      chk("m24_wrap", wrap_o[1], 1);
      chk("m24_tc_lo", tc_o[1], 0);
      tick();
      chk("m24_bin22", bin_o[1], 22);
      chk("m24_gray1d", gray_o[1], 'h1D);
      chk("m24_nowrap", wrap_o[1], 0);
      idle_all();

      // Saturate at top, then reverse
      ld_v[0] = 1'b1; lg_v[0] = 16'h8;
      tick();
      chk("sat_loaded", bin_o[0], 15);
      ld_v[0] = 1'b0; sat_v[0] = 1'b1; up_v[0] = 1'b1; en_v[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sat_hold_bin", bin_o[0], 15);
         chk("sat_hold_gray", gray_o[0], 8);
         chk("sat_wrap", wrap_o[0], 0);
         chk("sat_tc", tc_o[0], 1);
      end
      up_v[0] = 1'b0;
      tick();
      chk("sat_reverse", bin_o[0], 14);

      // Load wins over enable
      ld_v[0] = 1'b1; lg_v[0] = 16'h6; en_v[0] = 1'b1; up_v[0] = 1'b1; sat_v[0] = 1'b0;
      tick();
      chk("ld_bin", bin_o[0], 4);
      chk("ld_gray", gray_o[0], 6);
      chk("ld_wrap", wrap_o[0], 0);
      idle_all();

      // Out-of-range load on modulus 10
      ld_v[2] = 1'b1; lg_v[2] = 16'hF;
      tick();
      chk("ld_err_bin", bin_o[2], 0);
      chk("ld_err_pulse", err_o[2], 1);
      ld_v[2] = 1'b0;
      tick();
      chk("ld_err_clear", err_o[2], 0);

      // Reset beats load and enable
      for (int d = 0; d < 3; d++) begin
         ld_v[d] = 1'b1; en_v[d] = 1'b1; up_v[d] = 1'b1; lg_v[d] = 16'h3;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rstov_bin%0d", d), bin_o[d], 0);
         chk($sformatf("rstov_gray%0d", d), gray_o[d], 0);
         chk($sformatf("rstov_tc%0d", d), tc_o[d], 0);
      end
      idle_all();

      // Random traffic on all three configurations
      for (int c = 0; c < 10000; c++) begin
         reset = ($urandom % 500) == 0;
         for (int d = 0; d < 3; d++) begin
            en_v[d]  = ($urandom % 4) != 0;
            up_v[d]  = 1'($urandom);
            sat_v[d] = ($urandom % 6) == 0;
            ld_v[d]  = ($urandom % 16) == 0;
            lg_v[d]  = 16'($urandom & ((32'd1 << wids[d]) - 1));
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
